// File: rtl/seq_gate_pkg.sv
// Shared types for the sequence-gated enable FSM: state encoding and counter width.
package seq_gate_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SEARCH = 3'd2,
        GRANT  = 3'd3,
        PASS   = 3'd4,
        DENY   = 3'd5
    } state_e;

    localparam int unsigned CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/seq_gate_fsm_if.sv
// Sensor/actuator side signals of the sequencer; master drives x/y, slave is the FSM.
interface seq_gate_fsm_if;

    logic x;
    logic y;
    logic f;
    logic g;
    logic done;
    logic pass;

    modport master (output x, output y, input f, input g, input done, input pass);
    modport slave  (input x, input y, output f, output g, output done, output pass);

endinterface

// File: rtl/seq_gate_matcher.sv
// Sliding-window pattern detector: PAT_LEN-bit history, saturating fill count, match on the
// window that includes the current sample.
module seq_gate_matcher #(
    parameter int unsigned        PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic hit
);

    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_LEN);

    typedef logic [PAT_LEN-1:0] hist_t;

    hist_t             hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        hit    = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            // Oldest sample falls off the MSB end.
            hist_d = hist_t'({hist_q, x});
            if (fill_q != FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
            hit = (fill_d == FULL) && (hist_d == PATTERN);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_gate_fsm.sv
// Motor-enable sequencer: start pulse, pattern watch, grant window with acknowledge.
// Define SEQ_GATE_RETRY_EN to make DENY a one-cycle state that returns to SEARCH.
module seq_gate_fsm
    import seq_gate_pkg::*;
#(
    parameter int unsigned        PAT_LEN  = 3,
    parameter logic [PAT_LEN-1:0] PATTERN  = 3'b101,
    parameter int unsigned        WIN      = 2,
    parameter int unsigned        F_CYCLES = 1
) (
    input logic           clk,
    input logic           resetn,
    seq_gate_fsm_if.slave bus
);

    localparam cnt_t F_LAST = cnt_t'(F_CYCLES - 1);
    localparam cnt_t W_LAST = cnt_t'(WIN - 1);

    state_e state_q, state_d;
    cnt_t   f_cnt_q, f_cnt_d;
    cnt_t   win_cnt_q, win_cnt_d;
    logic   f_q, g_q, done_q, pass_q;
    logic   hit, match_clr, match_en;

    // History is held clear outside SEARCH so each search (incl. a retry) starts fresh.
    assign match_en  = (state_q == SEARCH);
    assign match_clr = !match_en;

    seq_gate_matcher #(
        .PAT_LEN(PAT_LEN),
        .PATTERN(PATTERN)
    ) u_matcher (
        .clk   (clk),
        .resetn(resetn),
        .clr   (match_clr),
        .en    (match_en),
        .x     (bus.x),
        .hit   (hit)
    );

    always_comb begin
        state_d   = state_q;
        f_cnt_d   = f_cnt_q;
        win_cnt_d = win_cnt_q;
        case (state_q)
            IDLE: state_d = START;
            START: begin
                if (f_cnt_q == F_LAST) begin
                    state_d = SEARCH;
                    f_cnt_d = '0;
                end else begin
                    f_cnt_d = f_cnt_q + cnt_t'(1);
                end
            end
            SEARCH: if (hit) state_d = GRANT;
            GRANT: begin
                if (bus.y) begin
                    state_d   = PASS;
                    win_cnt_d = '0;
                end else if (win_cnt_q == W_LAST) begin
                    state_d   = DENY;
                    win_cnt_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + cnt_t'(1);
                end
            end
            PASS: state_d = PASS;
`ifdef SEQ_GATE_RETRY_EN
            DENY: state_d = SEARCH;
`else
            DENY: state_d = DENY;
`endif
            default: begin
                state_d   = IDLE;
                f_cnt_d   = '0;
                win_cnt_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state, so they always reflect state_q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            f_cnt_q   <= '0;
            win_cnt_q <= '0;
            f_q       <= 1'b0;
            g_q       <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            f_cnt_q   <= f_cnt_d;
            win_cnt_q <= win_cnt_d;
            f_q       <= (state_d == START);
            g_q       <= (state_d == GRANT) || (state_d == PASS);
            done_q    <= (state_d == PASS) || (state_d == DENY);
            pass_q    <= (state_d == PASS);
        end
    end

    assign bus.f    = f_q;
    assign bus.g    = g_q;
    assign bus.done = done_q;
    assign bus.pass = pass_q;

endmodule

// File: tb/tb_seq_gate_fsm.sv
// Bench for seq_gate_fsm: directed vector tables, corner sequences and a random run against
// a queue-based reference model. Honours SEQ_GATE_RETRY_EN like the design.
module tb_seq_gate_fsm;

    localparam int       P_LEN = 3;
    localparam bit [2:0] P_PAT = 3'b101;
    localparam int       P_WIN = 2;
    localparam int       P_F   = 1;
`ifdef SEQ_GATE_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic resetn2 = 1'b0;
    always #5 clk = ~clk;

    seq_gate_fsm_if bus1 ();
    seq_gate_fsm_if bus2 ();

    seq_gate_fsm dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus1)
    );

    seq_gate_fsm #(
        .PAT_LEN (4),
        .PATTERN (4'b1101),
        .WIN     (3),
        .F_CYCLES(3)
    ) dut2 (
        .clk   (clk),
        .resetn(resetn2),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit         rst;
        bit         x;
        bit         y;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[$];

    // Reference model: cycle index since reset release, raw sample queue, window bookkeeping.
    int m_t;
    int m_search_from;
    int m_win_start;
    int m_deny_cycle;
    bit m_passed;
    bit m_denied;
    bit m_hist[$];

    // Second-config stimulus, one entry per cycle after release.
    bit         x2[12]   = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0};
    bit         y2[12]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [3:0] exp2[12] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000,
                             4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0111, 4'b0111};
    bit         ov[7]    = '{1, 1, 0, 0, 1, 0, 1};

    function automatic logic [3:0] outs1();
        return {bus1.f, bus1.g, bus1.done, bus1.pass};
    endfunction

    function automatic logic [3:0] outs2();
        return {bus2.f, bus2.g, bus2.done, bus2.pass};
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d got fgdp=%b expected %b", name, m_t, act, exp);
        end
    endtask

    task automatic model_reset();
        m_t           = 0;
        m_search_from = P_F + 1;
        m_win_start   = -1;
        m_deny_cycle  = -1;
        m_passed      = 1'b0;
        m_denied      = 1'b0;
        m_hist.delete();
    endtask

    function automatic logic [3:0] model_exp();
        bit f;
        bit g;
        f = (m_t >= 1) && (m_t <= P_F);
        g = (m_win_start >= 0) && !m_denied;
        return {f, g, m_passed || m_denied, m_passed};
    endfunction

    task automatic model_update(input bit xi, input bit yi);
        bit [2:0] pat;
        bit       hit;
        pat = P_PAT;
        if (!m_passed) begin
            if (m_denied) begin
                if (RETRY && m_t == m_deny_cycle) begin
                    m_denied      = 1'b0;
                    m_win_start   = -1;
                    m_hist.delete();
                    m_search_from = m_t + 1;
                end
            end else if (m_win_start >= 0) begin
                if (yi) begin
                    m_passed = 1'b1;
                end else if (m_t - m_win_start == P_WIN - 1) begin
                    m_denied     = 1'b1;
                    m_deny_cycle = m_t + 1;
                end
            end else if (m_t >= m_search_from) begin
                m_hist.push_back(xi);
                if (m_hist.size() > P_LEN) void'(m_hist.pop_front());
                if (m_hist.size() == P_LEN) begin
                    hit = 1'b1;
                    for (int i = 0; i < P_LEN; i++) begin
                        if (m_hist[i] != pat[P_LEN-1-i]) hit = 1'b0;
                    end
                    if (hit) m_win_start = m_t + 1;
                end
            end
        end
        m_t++;
    endtask

    // Called just after a negedge: check this cycle, drive its inputs, advance one cycle.
    task automatic step(input bit xi, input bit yi);
        chk("model", outs1(), model_exp());
        bus1.x = xi;
        bus1.y = yi;
        model_update(xi, yi);
        @(negedge clk);
    endtask

    // Asynchronous drop between edges, then release on a negedge so the next cycle is cycle 0.
    task automatic do_reset();
        #2 resetn = 1'b0;
        #1 chk("async_reset", outs1(), 4'b0000);
        bus1.x = 1'b0;
        bus1.y = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic add(input bit r, input bit xi, input bit yi, input logic [3:0] e);
        vec_t v;
        v.rst = r;
        v.x   = xi;
        v.y   = yi;
        v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        bus1.x = 1'b0;
        bus1.y = 1'b0;
        bus2.x = 1'b0;
        bus2.y = 1'b0;
        model_reset();

        // Acknowledge in the last window cycle -> PASS held.
        add(1, 0, 0, 4'b0000); add(0, 0, 0, 4'b1000); add(0, 1, 0, 4'b0000);
        add(0, 0, 0, 4'b0000); add(0, 1, 0, 4'b0000); add(0, 0, 0, 4'b0100);
        add(0, 0, 1, 4'b0100); add(0, 0, 0, 4'b0111); add(0, 0, 0, 4'b0111);
        add(0, 0, 0, 4'b0111);
        // No acknowledge -> DENY (one cycle only when retry is built in).
        add(1, 0, 0, 4'b0000); add(0, 0, 0, 4'b1000); add(0, 1, 0, 4'b0000);
        add(0, 0, 0, 4'b0000); add(0, 1, 0, 4'b0000); add(0, 0, 0, 4'b0100);
        add(0, 0, 0, 4'b0100); add(0, 0, 0, 4'b0010);
        for (int i = 0; i < 3; i++) add(0, 0, 0, RETRY ? 4'b0000 : 4'b0010);

        @(negedge clk);
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            chk("table", outs1(), tbl[i].exp);
            step(tbl[i].x, tbl[i].y);
        end
        for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1'b0);

        // Overlapping stream: 110 and 001 must not match, the trailing 101 must.
        do_reset();
        step(0, 0);
        step(0, 0);
        for (int i = 0; i < 7; i++) begin
            chk("overlap_no_grant", {3'b000, bus1.g}, 4'b0000);
            step(ov[i], 1'b0);
        end
        chk("overlap_grant", {3'b000, bus1.g}, 4'b0001);
        step(0, 0);

        // Reset dropped while granting, then the full sequence again.
        do_reset();
        step(0, 0); step(0, 0); step(1, 0); step(0, 0); step(1, 0);
        chk("grant_before_reset", {3'b000, bus1.g}, 4'b0001);
        do_reset();
        step(0, 0); step(0, 0); step(1, 0); step(0, 0); step(1, 0);
        chk("grant_after_rerun", {3'b000, bus1.g}, 4'b0001);
        step(0, 0); step(0, 0); step(0, 0);

`ifdef SEQ_GATE_RETRY_EN
        do_reset();
        step(0, 0); step(0, 0); step(1, 0); step(0, 0); step(1, 0);
        step(0, 0);
        step(1, 0);
        chk("retry_deny", outs1(), 4'b0010);
        step(1, 0);
        chk("retry_search", outs1(), 4'b0000);
        step(0, 0);
        step(1, 0);
        chk("retry_no_stale", {3'b000, bus1.g}, 4'b0000);
        step(1, 0);
        step(0, 0);
        step(1, 0);
        chk("retry_regrant", {3'b000, bus1.g}, 4'b0001);
        step(0, 0);
`endif

        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            end
        end

        // Longer pattern, wider window, longer start pulse.
        resetn2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("cfg4", outs2(), exp2[i]);
            bus2.x = x2[i];
            bus2.y = y2[i];
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
